// File: rtl/bht_btb_pkg.sv
// Shared definitions for the BHT/BTB table and its controller: entry field
// layout, default geometry and the table FSM state encoding.
package bht_btb_pkg;

  localparam int ADDR_WIDTH_DEF = 6;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int DEPTH          = 1 << ADDR_WIDTH_DEF;

  localparam int TARGET_LSB = 0;
  localparam int TARGET_MSB = 10;
  localparam int TAG_LSB    = 11;
  localparam int TAG_MSB    = 15;
  localparam int VALID_BIT  = 16;
  localparam int CNT_LSB    = 17;
  localparam int CNT_MSB    = 18;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  function automatic int depth_of(input int addr_width);
    return 1 << addr_width;
  endfunction

endpackage

// File: rtl/bht_btb_mem_array.sv
// Raw entry storage: two write ports with port 2 taking priority on an
// address collision, and two asynchronous read taps feeding the top level.
module bht_btb_mem_array
  import bht_btb_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic [ADDR_WIDTH-1:0] i_addr1,
  input  logic                  i_we1,
  input  logic [DATA_WIDTH-1:0] i_wdata1,
  output logic [DATA_WIDTH-1:0] o_rdata1,
  input  logic [ADDR_WIDTH-1:0] i_addr2,
  input  logic                  i_we2,
  input  logic [DATA_WIDTH-1:0] i_wdata2,
  output logic [DATA_WIDTH-1:0] o_rdata2
);

  localparam int DEPTH_L = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH_L];
  logic                  w_p1_blocked;

  // Port 1 yields when port 2 writes the same entry in the same cycle.
  assign w_p1_blocked = i_we2 && (i_addr1 == i_addr2);

  always_ff @(posedge clk) begin
    if (i_we2) r_mem[i_addr2] <= i_wdata2;
    if (i_we1 && !w_p1_blocked) r_mem[i_addr1] <= i_wdata1;
  end

  assign o_rdata1 = r_mem[i_addr1];
  assign o_rdata2 = r_mem[i_addr2];

endmodule

// File: rtl/bht_btb_table.sv
// Dual-port BHT/BTB table with a power-on/flush clear sweep, registered
// write-first reads and cross-port bypass so an update is visible at once.
module bht_btb_table
  import bht_btb_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic [ADDR_WIDTH-1:0] address1,
  input  logic                  wr_enable1,
  input  logic [DATA_WIDTH-1:0] wr_data1,
  output logic [DATA_WIDTH-1:0] rd_data1,
  input  logic [ADDR_WIDTH-1:0] address2,
  input  logic                  wr_enable2,
  input  logic [DATA_WIDTH-1:0] wr_data2,
  output logic [DATA_WIDTH-1:0] rd_data2,
  output logic                  init_busy,
  output logic                  dbg_state,
  output logic [ADDR_WIDTH-1:0] dbg_clear_idx
);

  state_e                r_state;
  logic [ADDR_WIDTH-1:0] r_clear_idx;
  logic                  r_init_busy;
  logic [DATA_WIDTH-1:0] r_rd_data1;
  logic [DATA_WIDTH-1:0] r_rd_data2;

  logic                  w_run;
  logic                  w_we1;
  logic                  w_we2;
  logic                  w_arr_we2;
  logic [ADDR_WIDTH-1:0] w_arr_addr2;
  logic [DATA_WIDTH-1:0] w_arr_wdata2;
  logic [DATA_WIDTH-1:0] w_mem_rd1;
  logic [DATA_WIDTH-1:0] w_mem_rd2;
  logic                  w_same_addr;
  logic [DATA_WIDTH-1:0] w_next_rd1;
  logic [DATA_WIDTH-1:0] w_next_rd2;

  assign w_run = (r_state == ST_RUN);
  assign w_we1 = w_run && wr_enable1;
  assign w_we2 = w_run && wr_enable2;

  // During the sweep port 2 of the array is borrowed to write zeros.
  assign w_arr_we2    = !w_run || w_we2;
  assign w_arr_addr2  = w_run ? address2 : r_clear_idx;
  assign w_arr_wdata2 = w_run ? wr_data2 : '0;

  bht_btb_mem_array #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mem (
    .clk      (clk),
    .i_addr1  (address1),
    .i_we1    (w_we1),
    .i_wdata1 (wr_data1),
    .o_rdata1 (w_mem_rd1),
    .i_addr2  (w_arr_addr2),
    .i_we2    (w_arr_we2),
    .i_wdata2 (w_arr_wdata2),
    .o_rdata2 (w_mem_rd2)
  );

  assign w_same_addr = (address1 == address2);

  // Bypass order mirrors the array: port 2 data wins, then port 1, then storage.
  always_comb begin
    w_next_rd1 = w_mem_rd1;
    if (w_we2 && w_same_addr) w_next_rd1 = wr_data2;
    else if (w_we1)           w_next_rd1 = wr_data1;

    w_next_rd2 = w_mem_rd2;
    if (w_we2)                     w_next_rd2 = wr_data2;
    else if (w_we1 && w_same_addr) w_next_rd2 = wr_data1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_CLEAR;
      r_clear_idx <= '0;
      r_init_busy <= 1'b1;
      r_rd_data1  <= '0;
      r_rd_data2  <= '0;
    end else begin
      unique case (r_state)
        ST_CLEAR: begin
          r_rd_data1 <= '0;
          r_rd_data2 <= '0;
          if (flush) begin
            r_clear_idx <= '0;
          end else if (r_clear_idx == {ADDR_WIDTH{1'b1}}) begin
            r_state     <= ST_RUN;
            r_init_busy <= 1'b0;
            r_clear_idx <= '0;
          end else begin
            r_clear_idx <= r_clear_idx + 1'b1;
          end
        end
        ST_RUN: begin
          r_rd_data1 <= w_next_rd1;
          r_rd_data2 <= w_next_rd2;
          if (flush) begin
            r_state     <= ST_CLEAR;
            r_init_busy <= 1'b1;
            r_clear_idx <= '0;
          end
        end
      endcase
    end
  end

  assign rd_data1      = r_rd_data1;
  assign rd_data2      = r_rd_data2;
  assign init_busy     = r_init_busy;
  assign dbg_state     = r_state;
  assign dbg_clear_idx = r_clear_idx;

endmodule

// File: tb/tb_bht_btb_table.sv
// Directed bench for bht_btb_table: clear sweeps, read latency, write-first,
// cross-port bypass, port-2 priority, flush and mid-sweep reset.
module tb_bht_btb_table;

  localparam int AW = 6;
  localparam int DW = 32;

  logic          clk;
  logic          reset;
  logic          flush;
  logic [AW-1:0] address1;
  logic          wr_enable1;
  logic [DW-1:0] wr_data1;
  logic [DW-1:0] rd_data1;
  logic [AW-1:0] address2;
  logic          wr_enable2;
  logic [DW-1:0] wr_data2;
  logic [DW-1:0] rd_data2;
  logic          init_busy;
  logic          dbg_state;
  logic [AW-1:0] dbg_clear_idx;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] exp_q[$];

  typedef struct {
    string         name;
    logic          we1;
    logic [AW-1:0] a1;
    logic [DW-1:0] d1;
    logic          we2;
    logic [AW-1:0] a2;
    logic [DW-1:0] d2;
    logic [DW-1:0] exp1;
    logic [DW-1:0] exp2;
  } vec_t;

  vec_t vecs[12];

  bht_btb_table #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk           (clk),
    .reset         (reset),
    .flush         (flush),
    .address1      (address1),
    .wr_enable1    (wr_enable1),
    .wr_data1      (wr_data1),
    .rd_data1      (rd_data1),
    .address2      (address2),
    .wr_enable2    (wr_enable2),
    .wr_data2      (wr_data2),
    .rd_data2      (rd_data2),
    .init_busy     (init_busy),
    .dbg_state     (dbg_state),
    .dbg_clear_idx (dbg_clear_idx)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    flush      = 1'b0;
    wr_enable1 = 1'b0;
    wr_enable2 = 1'b0;
    wr_data1   = '0;
    wr_data2   = '0;
  endtask

  // Counts cycles with init_busy high; outputs must stay zero and a pair of
  // user writes attempted late in the sweep must be dropped.
  task automatic run_sweep(input string name);
    int   cnt;
    logic nonzero;
    cnt     = 0;
    nonzero = 1'b0;
    while (init_busy === 1'b1 && cnt < 200) begin
      cnt++;
      if (rd_data1 !== '0 || rd_data2 !== '0) nonzero = 1'b1;
      wr_enable1 = (cnt == 40);
      address1   = 6'h03;
      wr_data1   = 32'h0000_5678;
      wr_enable2 = (cnt == 40);
      address2   = 6'h07;
      wr_data2   = 32'h0000_1234;
      step();
    end
    idle_inputs();
    check({name, "_busy_cycles"}, DW'(cnt), DW'(64));
    check({name, "_rd_zero_during_sweep"}, DW'(nonzero), DW'(0));
  endtask

  task automatic read_pair(input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                           output logic [DW-1:0] r1, output logic [DW-1:0] r2);
    address1 = a1;
    address2 = a2;
    step();
    r1 = rd_data1;
    r2 = rd_data2;
  endtask

  initial begin
    logic [DW-1:0] r1, r2;
    int guard;

    vecs[0]  = '{"rd_2a_after_init", 1'b0, 6'h2A, 32'h0, 1'b0, 6'h00, 32'h0, 32'h0, 32'h0};
    vecs[1]  = '{"p2_wr_05", 1'b0, 6'h00, 32'h0, 1'b1, 6'h05, 32'h0005_8123, 32'h0, 32'h0005_8123};
    vecs[2]  = '{"rd_05", 1'b0, 6'h05, 32'h0, 1'b0, 6'h05, 32'h0, 32'h0005_8123, 32'h0005_8123};
    vecs[3]  = '{"bypass_p2_to_p1", 1'b0, 6'h11, 32'h0, 1'b1, 6'h11, 32'h0006_0400, 32'h0006_0400, 32'h0006_0400};
    vecs[4]  = '{"both_wr_3f", 1'b1, 6'h3F, 32'h1111_1111, 1'b1, 6'h3F, 32'h2222_2222, 32'h2222_2222, 32'h2222_2222};
    vecs[5]  = '{"rd_3f", 1'b0, 6'h3F, 32'h0, 1'b0, 6'h3F, 32'h0, 32'h2222_2222, 32'h2222_2222};
    vecs[6]  = '{"bypass_p1_to_p2", 1'b1, 6'h20, 32'h0001_ABCD, 1'b0, 6'h20, 32'h0, 32'h0001_ABCD, 32'h0001_ABCD};
    vecs[7]  = '{"indep_writes", 1'b1, 6'h21, 32'hAAAA_0001, 1'b1, 6'h22, 32'hBBBB_0002, 32'hAAAA_0001, 32'hBBBB_0002};
    vecs[8]  = '{"rd_cross", 1'b0, 6'h22, 32'h0, 1'b0, 6'h21, 32'h0, 32'hBBBB_0002, 32'hAAAA_0001};
    vecs[9]  = '{"rd_11_2a", 1'b0, 6'h11, 32'h0, 1'b0, 6'h2A, 32'h0, 32'h0006_0400, 32'h0};
    vecs[10] = '{"p1_wr_07", 1'b1, 6'h07, 32'h0007_FFFF, 1'b0, 6'h05, 32'h0, 32'h0007_FFFF, 32'h0005_8123};
    vecs[11] = '{"rd_07_3f", 1'b0, 6'h07, 32'h0, 1'b0, 6'h3F, 32'h0, 32'h0007_FFFF, 32'h2222_2222};

    // Reset values
    idle_inputs();
    address1 = '0;
    address2 = '0;
    reset    = 1'b1;
    #1;
    check("reset_rd1", rd_data1, '0);
    check("reset_rd2", rd_data2, '0);
    check("reset_busy", DW'(init_busy), DW'(1));
    check("reset_state_clear", DW'(dbg_state), DW'(0));
    step();
    step();
    reset = 1'b0;

    // Initial sweep
    run_sweep("init");
    check("init_state_run", DW'(dbg_state), DW'(1));

    // Table-driven RUN traffic
    for (int i = 0; i < 12; i++) begin
      wr_enable1 = vecs[i].we1;
      address1   = vecs[i].a1;
      wr_data1   = vecs[i].d1;
      wr_enable2 = vecs[i].we2;
      address2   = vecs[i].a2;
      wr_data2   = vecs[i].d2;
      exp_q.push_back(vecs[i].exp1);
      exp_q.push_back(vecs[i].exp2);
      step();
      check({vecs[i].name, "_rd1"}, rd_data1, exp_q.pop_front());
      check({vecs[i].name, "_rd2"}, rd_data2, exp_q.pop_front());
    end
    idle_inputs();

    // Flush from RUN, dropped writes during the sweep, contents cleared
    address1 = 6'h2A;
    address2 = 6'h2A;
    flush    = 1'b1;
    step();
    flush = 1'b0;
    check("flush_busy_next", DW'(init_busy), DW'(1));
    run_sweep("flush");
    read_pair(6'h07, 6'h03, r1, r2);
    check("flush_rd_07", r1, '0);
    check("flush_rd_03", r2, '0);
    read_pair(6'h05, 6'h3F, r1, r2);
    check("flush_rd_05", r1, '0);
    check("flush_rd_3f", r2, '0);

    // Flush mid-sweep restarts the index
    wr_enable2 = 1'b1;
    address2   = 6'h09;
    wr_data2   = 32'h0000_0999;
    step();
    idle_inputs();
    flush = 1'b1;
    step();
    flush = 1'b0;
    guard = 0;
    while (dbg_clear_idx != 6'd10 && guard < 100) begin
      guard++;
      step();
    end
    check("mid_flush_reach_idx10", DW'(guard < 100), DW'(1));
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("mid_flush_idx_restart", DW'(dbg_clear_idx), DW'(0));
    run_sweep("mid_flush");
    read_pair(6'h09, 6'h09, r1, r2);
    check("mid_flush_rd_09", r1, '0);

    // Reset at clear_idx 30
    wr_enable1 = 1'b1;
    address1   = 6'h05;
    wr_data1   = 32'h0005_0505;
    step();
    idle_inputs();
    flush = 1'b1;
    step();
    flush = 1'b0;
    guard = 0;
    while (dbg_clear_idx != 6'd30 && guard < 100) begin
      guard++;
      step();
    end
    check("rst_reach_idx30", DW'(guard < 100), DW'(1));
    reset = 1'b1;
    #1;
    check("rst_async_idx", DW'(dbg_clear_idx), DW'(0));
    check("rst_async_busy", DW'(init_busy), DW'(1));
    step();
    step();
    reset = 1'b0;
    address1 = 6'h05;
    address2 = 6'h05;
    run_sweep("rst_mid");
    read_pair(6'h05, 6'h05, r1, r2);
    check("rst_mid_rd_05", r1, '0);
    check("rst_mid_rd2_05", r2, '0);

    // Final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
